// File: rtl/axi_pkg.sv
// Shared types for the AXI outstanding-transaction limiter: counter widths and
// a compact AXI request/response payload used as the default bus type.
package axi_pkg;

  localparam int unsigned CntW   = 8;
  localparam int unsigned StallW = 32;
  localparam int unsigned IdW    = 4;
  localparam int unsigned AddrW  = 32;
  localparam int unsigned DataW  = 32;

  typedef logic [CntW-1:0]   cnt_t;
  typedef logic [StallW-1:0] stall_cnt_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
  } ax_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } rsp_t;

endpackage

// File: rtl/axi_outstanding_limiter_if.sv
// Request/response bundle for one side of the limiter; master drives req, slave drives rsp.
interface axi_outstanding_limiter_if #(
  parameter type req_t = axi_pkg::req_t,
  parameter type rsp_t = axi_pkg::rsp_t
);
  req_t req;
  rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/axi_txn_counter.sv
// Saturating-at-zero outstanding-transaction counter with full flag and sticky underflow.
module axi_txn_counter
  import axi_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  input  cnt_t max,
  output cnt_t cnt,
  output logic full,
  output logic underflow
);

  cnt_t cnt_q;
  logic uf_q;

  // Simultaneous inc and dec cancel; a dec at zero holds zero and flags an error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      uf_q  <= 1'b0;
    end else if (inc && !dec) begin
      cnt_q <= cnt_q + cnt_t'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) uf_q  <= 1'b1;
      else             cnt_q <= cnt_q - cnt_t'(1);
    end
  end

  assign cnt       = cnt_q;
  assign full      = (cnt_q == max);
  assign underflow = uf_q;

  // Upstream gating must keep the count from ever passing its limit.
  a_cnt_le_max: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= max);

endmodule

// File: rtl/axi_outstanding_limiter.sv
// Caps outstanding AXI writes/reads by gating AW/AR valid/ready; zero added latency.
// Optional stall statistics enabled with AXI_OUTSTANDING_LIMITER_STATS_EN.
module axi_outstanding_limiter #(
  parameter type         axi_req_t = axi_pkg::req_t,
  parameter type         axi_rsp_t = axi_pkg::rsp_t,
  parameter int unsigned MaxWrTxns = 4,
  parameter int unsigned MaxRdTxns = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  axi_req_t            slv_req_i,
  output axi_rsp_t            slv_resp_o,
  output axi_req_t            mst_req_o,
  input  axi_rsp_t            mst_resp_i,
  output axi_pkg::cnt_t       wr_cnt_o,
  output axi_pkg::cnt_t       rd_cnt_o,
  output logic                err_o,
  output axi_pkg::stall_cnt_t aw_stall_cnt_o,
  output axi_pkg::stall_cnt_t ar_stall_cnt_o
);

  logic wr_full, rd_full;
  logic wr_uf, rd_uf;
  logic aw_hs, b_hs, ar_hs, r_last_hs;

  // Everything passes straight through except the AW/AR valid/ready pairs.
  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & ~wr_full;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ~rd_full;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~wr_full;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~rd_full;
  end

  assign aw_hs     = slv_req_i.aw_valid & mst_resp_i.aw_ready & ~wr_full;
  assign ar_hs     = slv_req_i.ar_valid & mst_resp_i.ar_ready & ~rd_full;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

  axi_txn_counter u_wr_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc       (aw_hs),
    .dec       (b_hs),
    .max       (axi_pkg::cnt_t'(MaxWrTxns)),
    .cnt       (wr_cnt_o),
    .full      (wr_full),
    .underflow (wr_uf)
  );

  axi_txn_counter u_rd_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc       (ar_hs),
    .dec       (r_last_hs),
    .max       (axi_pkg::cnt_t'(MaxRdTxns)),
    .cnt       (rd_cnt_o),
    .full      (rd_full),
    .underflow (rd_uf)
  );

  assign err_o = wr_uf | rd_uf;

`ifdef AXI_OUTSTANDING_LIMITER_STATS_EN
  axi_pkg::stall_cnt_t aw_stall_q, ar_stall_q;

  // Cycles where an address request waits on a full limiter, saturating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_stall_q <= '0;
      ar_stall_q <= '0;
    end else begin
      if (slv_req_i.aw_valid && wr_full && (aw_stall_q != '1))
        aw_stall_q <= aw_stall_q + axi_pkg::stall_cnt_t'(1);
      if (slv_req_i.ar_valid && rd_full && (ar_stall_q != '1))
        ar_stall_q <= ar_stall_q + axi_pkg::stall_cnt_t'(1);
    end
  end

  assign aw_stall_cnt_o = aw_stall_q;
  assign ar_stall_cnt_o = ar_stall_q;
`else
  assign aw_stall_cnt_o = '0;
  assign ar_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Directed bench for axi_outstanding_limiter (MaxWrTxns = 2, MaxRdTxns = 4).
module tb_axi_outstanding_limiter;
  import axi_pkg::*;

`ifdef AXI_OUTSTANDING_LIMITER_STATS_EN
  localparam int unsigned StatsOn = 1;
`else
  localparam int unsigned StatsOn = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  cnt_t       wr_cnt, rd_cnt;
  logic       err;
  stall_cnt_t aw_stall, ar_stall;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  axi_outstanding_limiter_if slv_bus ();
  axi_outstanding_limiter_if mst_bus ();

  axi_outstanding_limiter #(
    .MaxWrTxns (2),
    .MaxRdTxns (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .slv_req_i      (slv_bus.req),
    .slv_resp_o     (slv_bus.rsp),
    .mst_req_o      (mst_bus.req),
    .mst_resp_i     (mst_bus.rsp),
    .wr_cnt_o       (wr_cnt),
    .rd_cnt_o       (rd_cnt),
    .err_o          (err),
    .aw_stall_cnt_o (aw_stall),
    .ar_stall_cnt_o (ar_stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    slv_bus.req = '0;
    mst_bus.rsp = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check_eq("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_aw_stall", aw_stall, 32'd0);
    check_eq("rst_ar_stall", ar_stall, 32'd0);

    // Pass-through of W and AW payload
    slv_bus.req.w_valid    = 1'b1;
    slv_bus.req.w.data     = 32'hDEADBEEF;
    slv_bus.req.aw.addr    = 32'h0000_0100;
    mst_bus.rsp.w_ready    = 1'b1;
    #1;
    check_eq("pt_w_data", mst_bus.req.w.data, 32'hDEADBEEF);
    check_eq("pt_w_valid", 32'(mst_bus.req.w_valid), 32'd1);
    check_eq("pt_w_ready", 32'(slv_bus.rsp.w_ready), 32'd1);
    check_eq("pt_aw_addr", mst_bus.req.aw.addr, 32'h0000_0100);
    check_eq("pt_aw_valid_idle", 32'(mst_bus.req.aw_valid), 32'd0);
    slv_bus.req.w_valid = 1'b0;
    mst_bus.rsp.w_ready = 1'b0;

    // Three AWs against a limit of two, B held off
    mst_bus.rsp.aw_ready = 1'b1;
    slv_bus.req.aw_valid = 1'b1;
    #1;
    check_eq("aw1_slv_ready", 32'(slv_bus.rsp.aw_ready), 32'd1);
    check_eq("aw1_mst_valid", 32'(mst_bus.req.aw_valid), 32'd1);
    tick();
    check_eq("aw1_wr_cnt", 32'(wr_cnt), 32'd1);
    slv_bus.req.aw.addr = 32'h0000_0200;
    #1;
    check_eq("aw2_slv_ready", 32'(slv_bus.rsp.aw_ready), 32'd1);
    tick();
    check_eq("aw2_wr_cnt", 32'(wr_cnt), 32'd2);
    check_eq("aw3_slv_ready_stalled", 32'(slv_bus.rsp.aw_ready), 32'd0);
    check_eq("aw3_mst_valid_gated", 32'(mst_bus.req.aw_valid), 32'd0);
    repeat (10) tick();
    check_eq("aw_stall_10", aw_stall, (StatsOn != 0) ? 32'd10 : 32'd0);
    check_eq("wr_cnt_held_full", 32'(wr_cnt), 32'd2);

    // One B frees a slot; the stalled AW goes through on the following cycle
    mst_bus.rsp.b_valid = 1'b1;
    slv_bus.req.b_ready = 1'b1;
    #1;
    check_eq("b_cycle_aw_still_stalled", 32'(slv_bus.rsp.aw_ready), 32'd0);
    check_eq("pt_b_valid", 32'(slv_bus.rsp.b_valid), 32'd1);
    tick();
    mst_bus.rsp.b_valid = 1'b0;
    #1;
    check_eq("after_b_wr_cnt", 32'(wr_cnt), 32'd1);
    check_eq("after_b_aw_ready", 32'(slv_bus.rsp.aw_ready), 32'd1);
    check_eq("after_b_mst_aw_valid", 32'(mst_bus.req.aw_valid), 32'd1);
    tick();
    slv_bus.req.aw_valid = 1'b0;
    check_eq("aw3_accepted_wr_cnt", 32'(wr_cnt), 32'd2);
    check_eq("aw_stall_11", aw_stall, (StatsOn != 0) ? 32'd11 : 32'd0);

    // Drain then one extra B to underflow
    mst_bus.rsp.b_valid = 1'b1;
    tick();
    tick();
    check_eq("drained_wr_cnt", 32'(wr_cnt), 32'd0);
    check_eq("drained_err", 32'(err), 32'd0);
    tick();
    mst_bus.rsp.b_valid = 1'b0;
    check_eq("uf_wr_cnt", 32'(wr_cnt), 32'd0);
    check_eq("uf_err", 32'(err), 32'd1);
    tick();
    tick();
    check_eq("uf_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("err_cleared_by_rst", 32'(err), 32'd0);
    check_eq("stall_cleared_by_rst", aw_stall, 32'd0);

    // Reads: one AR, then AR and R-last together
    mst_bus.rsp.ar_ready = 1'b1;
    slv_bus.req.ar_valid = 1'b1;
    tick();
    check_eq("ar1_rd_cnt", 32'(rd_cnt), 32'd1);
    mst_bus.rsp.r_valid  = 1'b1;
    mst_bus.rsp.r.last   = 1'b1;
    mst_bus.rsp.r.data   = 32'hCAFE0001;
    slv_bus.req.r_ready  = 1'b1;
    #1;
    check_eq("ar_r_same_ar_ready", 32'(slv_bus.rsp.ar_ready), 32'd1);
    check_eq("pt_r_data", slv_bus.rsp.r.data, 32'hCAFE0001);
    tick();
    check_eq("ar_r_same_rd_cnt", 32'(rd_cnt), 32'd1);
    slv_bus.req.ar_valid = 1'b0;

    // 4-beat burst retires only on its last beat
    for (int b = 1; b <= 4; b++) begin
      mst_bus.rsp.r.last = (b == 4);
      tick();
      check_eq($sformatf("burst_beat%0d_rd_cnt", b), 32'(rd_cnt), (b == 4) ? 32'd0 : 32'd1);
    end
    mst_bus.rsp.r_valid = 1'b0;
    mst_bus.rsp.r.last  = 1'b0;

    // Fill the read limit
    slv_bus.req.ar_valid = 1'b1;
    repeat (4) tick();
    check_eq("rd_full_cnt", 32'(rd_cnt), 32'd4);
    check_eq("rd_full_ar_ready", 32'(slv_bus.rsp.ar_ready), 32'd0);
    check_eq("rd_full_mst_ar_valid", 32'(mst_bus.req.ar_valid), 32'd0);
    tick();
    check_eq("ar_stall_1", ar_stall, (StatsOn != 0) ? 32'd1 : 32'd0);
    check_eq("rd_cnt_capped", 32'(rd_cnt), 32'd4);
    slv_bus.req.ar_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
